// File: rtl/gomoku_board_writer_if.sv
// Move request / response bundle for gomoku_board_writer.
// The player side drives the request; the board writer answers with a
// one-cycle result strobe and a result code.
interface gomoku_board_writer_if;
    logic       mv_valid;
    logic [5:0] mv_idx;
    logic       mv_ready;
    logic       rsp_valid;
    logic [1:0] rsp_code;

    modport master (
        output mv_valid,
        output mv_idx,
        input  mv_ready,
        input  rsp_valid,
        input  rsp_code
    );

    modport slave (
        input  mv_valid,
        input  mv_idx,
        output mv_ready,
        output rsp_valid,
        output rsp_code
    );
endinterface

// File: rtl/gomoku_board_writer.sv
// gomoku_board_writer: sole writer of the gomoku board register read by the
// VGA pixel generator. Moves arrive over a valid/ready handshake, are checked
// against the game state, legal stones are written and the turn alternates.
// Optional feature macro GOMOKU_WIN_CHECK_EN: adds a sequential neighbour
// scan after each legal move that ends the game on WIN_LEN-in-a-row.
//
// state | meaning
// IDLE  | waiting for a move, mv_ready high
// CHECK | validate latched index, write the stone when legal
// SCAN  | probe one neighbour cell per cycle (win-check build only)
// RESP  | strobe rsp_valid, commit turn and game-over outcome
module gomoku_board_writer #(
    parameter int N       = 6,
    parameter int WIN_LEN = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    gomoku_board_writer_if.slave    mv_if,
    output logic [2*N*N-1:0]        board_o,
    output logic                    turn_o,
    output logic                    game_over_o,
    output logic [1:0]              winner_o
);

    localparam int         CELLS  = N * N;
    localparam int         BW     = 2 * CELLS;
    localparam logic [6:0] CELLS7 = 7'(CELLS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] RC_OK       = 2'd0;
    localparam logic [1:0] RC_OCCUPIED = 2'd1;
    localparam logic [1:0] RC_RANGE    = 2'd2;
    localparam logic [1:0] RC_OVER     = 2'd3;

    // The 6-bit index space and the 128-bit read window limit the board size.
    generate
        if (N < 2 || N > 7 || WIN_LEN < 2 || WIN_LEN > N) begin : g_bad_param
            $error("gomoku_board_writer: unsupported N / WIN_LEN");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [BW-1:0] board_q, board_d;
    logic          turn_q, turn_d;
    logic          over_q, over_d;
    logic [1:0]    winner_q, winner_d;
    logic [1:0]    rsp_code_q, rsp_code_d;
    logic [5:0]    stones_q, stones_d;

    logic [127:0]  board_ext;
    logic [1:0]    cur_cell;
    logic [1:0]    mover;
    logic          win_w;

    // Zero-padded read window so any 6-bit index can be looked up safely.
    assign board_ext = {{(128 - BW){1'b0}}, board_q};
    assign cur_cell  = board_ext[{idx_q, 1'b0} +: 2];
    assign mover     = {turn_q, ~turn_q};

`ifdef GOMOKU_WIN_CHECK_EN
    localparam int RW = $clog2(WIN_LEN) + 1;
    localparam int CW = $clog2(2 * WIN_LEN) + 1;

    logic [1:0]    dir_q, dir_d;
    logic          side_q, side_d;
    logic          alive_q, alive_d;
    logic          win_q, win_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] run_q, run_d, run_next;

    int            step_r, step_c, probe_off, probe_r, probe_c;
    logic          probe_in, probe_hit;
    logic [5:0]    probe_idx;
    logic [1:0]    probe_cell;

    // Locate the current probe cell; a hit extends the run only while no
    // earlier probe on this side has stopped it.
    always_comb begin
        step_r = 1;
        step_c = 0;
        case (dir_q)
            2'd0:    begin step_r = 0; step_c = 1;  end
            2'd1:    begin step_r = 1; step_c = 0;  end
            2'd2:    begin step_r = 1; step_c = 1;  end
            default: begin step_r = 1; step_c = -1; end
        endcase
        probe_off = WIN_LEN - int'(rem_q);
        if (side_q) begin
            probe_off = -probe_off;
        end
        probe_r    = int'(idx_q) / N + step_r * probe_off;
        probe_c    = int'(idx_q) % N + step_c * probe_off;
        probe_in   = (probe_r >= 0) && (probe_r < N) && (probe_c >= 0) && (probe_c < N);
        probe_idx  = probe_in ? 6'(probe_r * N + probe_c) : 6'd0;
        probe_cell = board_ext[{probe_idx, 1'b0} +: 2];
        probe_hit  = alive_q && probe_in && (probe_cell == mover);
        run_next   = run_q + CW'(probe_hit);
    end

    assign win_w = win_q;

    // Scan bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q   <= 2'd0;
            side_q  <= 1'b0;
            alive_q <= 1'b0;
            win_q   <= 1'b0;
            rem_q   <= '0;
            run_q   <= '0;
        end else begin
            dir_q   <= dir_d;
            side_q  <= side_d;
            alive_q <= alive_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            run_q   <= run_d;
        end
    end
`else
    assign win_w = 1'b0;
`endif

    // Move FSM: validation, board write, scan sequencing and game outcome.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        board_d    = board_q;
        turn_d     = turn_q;
        over_d     = over_q;
        winner_d   = winner_q;
        rsp_code_d = rsp_code_q;
        stones_d   = stones_q;
`ifdef GOMOKU_WIN_CHECK_EN
        dir_d      = dir_q;
        side_d     = side_q;
        alive_d    = alive_q;
        win_d      = win_q;
        rem_d      = rem_q;
        run_d      = run_q;
`endif
        if (clear_i) begin
            state_d  = S_IDLE;
            board_d  = '0;
            turn_d   = 1'b0;
            over_d   = 1'b0;
            winner_d = 2'b00;
            stones_d = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mv_if.mv_valid) begin
                        idx_d   = mv_if.mv_idx;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = S_RESP;
                    if (over_q) begin
                        rsp_code_d = RC_OVER;
                    end else if ({1'b0, idx_q} >= CELLS7) begin
                        rsp_code_d = RC_RANGE;
                    end else if (cur_cell != 2'b00) begin
                        rsp_code_d = RC_OCCUPIED;
                    end else begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (idx_q == 6'(i)) begin
                                board_d[2*i +: 2] = mover;
                            end
                        end
                        stones_d = stones_q + 6'd1;
`ifdef GOMOKU_WIN_CHECK_EN
                        // rsp_code is left untouched until the scan finishes
                        state_d = S_SCAN;
                        dir_d   = 2'd0;
                        side_d  = 1'b0;
                        alive_d = 1'b1;
                        win_d   = 1'b0;
                        rem_d   = RW'(WIN_LEN - 1);
                        run_d   = '0;
`else
                        rsp_code_d = RC_OK;
`endif
                    end
                end
`ifdef GOMOKU_WIN_CHECK_EN
                S_SCAN: begin
                    run_d = run_next;
                    if (rem_q == RW'(1)) begin
                        rem_d   = RW'(WIN_LEN - 1);
                        alive_d = 1'b1;
                        if (!side_q) begin
                            side_d = 1'b1;
                        end else begin
                            side_d = 1'b0;
                            run_d  = '0;
                            if (int'(run_next) + 1 >= WIN_LEN) begin
                                win_d = 1'b1;
                            end
                            dir_d = dir_q + 2'd1;
                            if (dir_q == 2'd3) begin
                                state_d    = S_RESP;
                                rsp_code_d = RC_OK;
                            end
                        end
                    end else begin
                        rem_d   = rem_q - RW'(1);
                        alive_d = probe_hit;
                    end
                end
`endif
                S_RESP: begin
                    state_d = S_IDLE;
                    if (rsp_code_q == RC_OK) begin
                        turn_d = ~turn_q;
                        if (win_w) begin
                            over_d   = 1'b1;
                            winner_d = mover;
                        end else if (stones_q == 6'(CELLS)) begin
                            over_d   = 1'b1;
                            winner_d = 2'b11;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Core state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= 6'd0;
            board_q    <= '0;
            turn_q     <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 2'b00;
            rsp_code_q <= RC_OK;
            stones_q   <= 6'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            rsp_code_q <= rsp_code_d;
            stones_q   <= stones_d;
        end
    end

    // A clear in the response cycle drops the strobe together with the move.
    assign mv_if.mv_ready  = (state_q == S_IDLE);
    assign mv_if.rsp_valid = (state_q == S_RESP) && !clear_i;
    assign mv_if.rsp_code  = rsp_code_q;
    assign board_o         = board_q;
    assign turn_o          = turn_q;
    assign game_over_o     = over_q;
    assign winner_o        = winner_q;

endmodule

// File: tb/tb_gomoku_board_writer.sv
// Testbench for gomoku_board_writer: table of moves plus hand-written
// clear / reset sequences; expected response codes go through a queue that
// the response monitor drains.
module tb_gomoku_board_writer;
    localparam int N     = 6;
    localparam int CELLS = N * N;
`ifdef GOMOKU_WIN_CHECK_EN
    localparam int EXP_LAT = 34;
    localparam int MID_CYC = 10;
`else
    localparam int EXP_LAT = 2;
    localparam int MID_CYC = 1;
`endif

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic [2*CELLS-1:0]   board;
    logic                 turn;
    logic                 game_over;
    logic [1:0]           winner;

    gomoku_board_writer_if bus ();

    gomoku_board_writer #(.N(N), .WIN_LEN(5)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .mv_if       (bus),
        .board_o     (board),
        .turn_o      (turn),
        .game_over_o (game_over),
        .winner_o    (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] idx;
        logic [1:0] code;
        logic       turn;
        logic       over;
        logic [1:0] winner;
    } vec_t;

    int                 total = 0;
    int                 bad   = 0;
    int                 rsp_count = 0;
    logic [1:0]         exp_q[$];
    logic [2*CELLS-1:0] exp_board = '0;
    logic               cur_turn  = 1'b0;
    vec_t               tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 1'b0);
            else chk("rsp_code", bus.rsp_code, exp_q.pop_front());
        end
    end

    task automatic do_move(input logic [5:0] idx, input logic [1:0] code, input logic t,
                           input logic ov, input logic [1:0] w);
        int lat;
        @(negedge clk);
        chk("mv_ready_idle", bus.mv_ready, 1'b1);
        if (code == 2'd0) exp_board[2*idx +: 2] = {cur_turn, ~cur_turn};
        exp_q.push_back(code);
        bus.mv_valid = 1'b1;
        bus.mv_idx   = idx;
        @(posedge clk);
        #1;
        bus.mv_valid = 1'b0;
        bus.mv_idx   = 6'h2a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 100);
        chk($sformatf("latency idx=%0d", idx), lat, EXP_LAT);
        if (lat >= 100) exp_q.delete();
        chk("turn_before_rsp", turn, cur_turn);
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", bus.rsp_valid, 1'b0);
        chk($sformatf("turn idx=%0d", idx), turn, t);
        chk($sformatf("game_over idx=%0d", idx), game_over, ov);
        chk($sformatf("winner idx=%0d", idx), winner, w);
        chk($sformatf("board idx=%0d", idx), board, exp_board);
        cur_turn = t;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_board = '0;
        cur_turn  = 1'b0;
    endtask

    // Black plays b0 + k*stride, white answers 30..33; black moves last.
    task automatic play_line(input int b0, input int stride, input logic win);
        int   idx;
        logic last;
        for (int k = 0; k < 9; k++) begin
            last = (k == 8);
            idx  = (k % 2 == 0) ? b0 + (k / 2) * stride : 30 + k / 2;
            do_move(6'(idx), 2'd0, (k % 2 == 0), last && win, (last && win) ? 2'b01 : 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        tbl[0] = '{6'd7,  2'd0, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{6'd7,  2'd1, 1'b1, 1'b0, 2'b00};
        tbl[2] = '{6'd36, 2'd2, 1'b1, 1'b0, 2'b00};
        tbl[3] = '{6'd63, 2'd2, 1'b1, 1'b0, 2'b00};
        tbl[4] = '{6'd8,  2'd0, 1'b0, 1'b0, 2'b00};
        tbl[5] = '{6'd0,  2'd0, 1'b1, 1'b0, 2'b00};

        bus.mv_valid = 1'b0;
        bus.mv_idx   = 6'd0;

        // A request during reset must not be taken.
        repeat (2) @(negedge clk);
        bus.mv_valid = 1'b1;
        bus.mv_idx   = 6'd3;
        @(negedge clk);
        chk("ready_in_reset", bus.mv_ready, 1'b1);
        bus.mv_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_board", board, '0);
        chk("rst_turn", turn, 1'b0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_winner", winner, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_code", bus.rsp_code, 2'd0);
        chk("rst_mv_ready", bus.mv_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            do_move(tbl[i].idx, tbl[i].code, tbl[i].turn, tbl[i].over, tbl[i].winner);
        end
        chk("cell7_black", board[15:14], 2'b01);

        // Clear in the cycle after a handshake drops the move.
        rc = rsp_count;
        @(negedge clk);
        bus.mv_valid = 1'b1;
        bus.mv_idx   = 6'd9;
        @(posedge clk);
        #1;
        bus.mv_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_board = '0;
        cur_turn  = 1'b0;
        @(negedge clk);
        chk("clr_board", board, '0);
        chk("clr_turn", turn, 1'b0);
        chk("clr_game_over", game_over, 1'b0);
        chk("clr_winner", winner, 2'b00);
        chk("clr_mv_ready", bus.mv_ready, 1'b1);
        repeat (40) @(negedge clk);
        chk("clr_no_rsp", rsp_count - rc, 0);

        // A request coinciding with clear is not accepted.
        @(negedge clk);
        clear = 1'b1;
        bus.mv_valid = 1'b1;
        bus.mv_idx   = 6'd1;
        @(negedge clk);
        clear = 1'b0;
        bus.mv_valid = 1'b0;
        chk("clr_valid_not_taken", bus.mv_ready, 1'b1);
        repeat (40) @(negedge clk);
        chk("clr_valid_no_rsp", rsp_count - rc, 0);

`ifndef GOMOKU_WIN_CHECK_EN
        // Fill the board: draw after the last stone, then game over.
        for (int i = 0; i < CELLS; i++) begin
            do_move(6'(i), 2'd0, (i % 2 == 0), (i == CELLS - 1), (i == CELLS - 1) ? 2'b11 : 2'b00);
        end
        do_move(6'd0, 2'd3, 1'b0, 1'b1, 2'b11);
`else
        do_clear();
        play_line(0, 1, 1'b1);
        do_move(6'd5, 2'd3, 1'b1, 1'b1, 2'b01);
        do_clear();
        play_line(5, 5, 1'b1);
        do_clear();
        play_line(4, 1, 1'b0);
`endif

        // Reset in the middle of a move.
        do_clear();
        do_move(6'd14, 2'd0, 1'b1, 1'b0, 2'b00);
        rc = rsp_count;
        @(negedge clk);
        bus.mv_valid = 1'b1;
        bus.mv_idx   = 6'd20;
        @(posedge clk);
        #1;
        bus.mv_valid = 1'b0;
        repeat (MID_CYC) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_board", board, '0);
        chk("mid_rst_turn", turn, 1'b0);
        chk("mid_rst_game_over", game_over, 1'b0);
        chk("mid_rst_winner", winner, 2'b00);
        chk("mid_rst_rsp_code", bus.rsp_code, 2'd0);
        chk("mid_rst_mv_ready", bus.mv_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_board = '0;
        cur_turn  = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_rsp", rsp_count - rc, 0);
        do_move(6'd7, 2'd0, 1'b1, 1'b0, 2'b00);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
